sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Single-port SRAM controller and arbiter shared by the instruction-fetch stage and the execute stage's memory access (load/store with byte enables). Sequences the asynchronous SRAM strobes over a programmable number of cycles, arbitrates between the two requesters with a req/ack handshake and returns registered read data. Sits between the CPU pipeline and the on-board base RAM.

## Interface
- RD_CYCLES, 2: cycles oe_n held low per read (≥1)
- WR_CYCLES, 2: cycles we_n held low per write (≥1)
- BASE_ADDR, 32'h8000_0000: byte address of RAM word 0
- RAM_AW, 20: SRAM word-address width; window is 4·2^RAM_AW bytes
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- if_req / if_addr  in  1/32  fetch request, byte address
- if_ack / if_err  out  1/1  one-cycle completion, address error
- if_rdata  out  32  fetched word, valid with if_ack
- dm_req / dm_we  in  1/1  data request; 1 = write
- dm_addr / dm_wdata  in  32/32  byte address, write data (already lane-aligned)
- dm_be_n  in  4  active-low byte enables
- dm_ack / dm_err  out  1/1  completion, address error
- dm_rdata  out  32  read word, valid with dm_ack
- ram_addr  out  RAM_AW  word address = addr[RAM_AW+1:2]
- ram_be_n  out  4  byte enables to SRAM
- ram_ce_n / ram_oe_n / ram_we_n  out  1 each  SRAM strobes
- ram_data_o / ram_data_oe  out  32/1  write data, bus drive enable
- ram_data_i  in  32  SRAM read data

## Operation
- States: IDLE, READ, WRITE, WREC, ACK.
- IDLE: sample requests at clock edge. Grant chosen (see Configuration); request fields latched. In-window address → READ (fetch or dm_we=0) or WRITE; out-of-window → ACK with err=1, no strobes.
- Window: BASE_ADDR ≤ addr < BASE_ADDR + 4·2^RAM_AW; addr[1:0] ignored for address, fetch uses be_n=4'b0000.
- READ: ce_n=0, oe_n=0, RD_CYCLES cycles; ram_data_i captured into granted rdata at last READ edge → ACK.
- WRITE: ce_n=0, we_n=0, ram_data_oe=1, WR_CYCLES cycles → WREC.
- WREC: one cycle, we_n=1, ce_n=0, data still driven (hold) → ACK.
- ACK: granted ack=1 (err as decided), strobes inactive, ram_data_oe=0; requests ignored → IDLE.
- Requester keeps req and fields stable until it sees ack; req still high in following IDLE cycle = new request.
- rdata holds last value until next read by same port; non-granted ack/err stay 0.
- Reset values: ram_ce_n/oe_n/we_n=1, ram_be_n=4'b1111, ram_addr=0, ram_data_o=0, ram_data_oe=0, all ack/err=0, rdata=0, state IDLE, last-grant=fetch.
- Reset mid-transaction: strobes deassert immediately (asynchronous), transaction aborted, no ack issued.

## Timing
- Edge E0 = IDLE edge sampling req. Read ack in cycle RD_CYCLES+1 after E0; write ack in cycle WR_CYCLES+2; error ack in cycle 1.
- Back-to-back throughput: read RD_CYCLES+2 cycles, write WR_CYCLES+3 cycles.
- All outputs registered; no combinational path req→ack.

## Configuration
- SRAM_ARB_RR_EN defined: round-robin; both requesting in IDLE → grant the port not granted last; single requester always granted.
- Undefined: fixed priority, data port always wins over fetch.

## Structure
- Shared package: state encoding, byte-enable constants (word 4'b0000, bytes 0–3 as 4'b1110/1101/1011/0111), default timing constants.
- One sub-module natural: sram_arb_pick (combinational grant selection incl. round-robin pointer input); FSM and datapath in top.

## Test plan
- Reset held then released, no req → strobes 1, ram_be_n=4'b1111, ram_data_oe=0, acks 0 for 20 cycles.
- if_req addr 0x8000_0010, model word 4 = 0x12345678, RD_CYCLES=2 → ram_addr=4, oe_n low 2 cycles, if_ack in cycle 3 after E0, if_rdata=0x12345678.
- dm write addr 0x8000_0003, be_n 4'b0111, wdata 0xAB00_0000 → we_n low 2 cycles, be_n 0111, data held through WREC, dm_ack cycle 4; model byte 3 of word 0 = 0xAB, others unchanged.
- Both req held for four transactions → undefined macro: dm,dm,dm,dm while dm held, fetch starved; with SRAM_ARB_RR_EN: dm,if,dm,if.
- dm read addr 0x0000_1000 → dm_ack and dm_err=1 in cycle 1, ram_ce_n never 0.
- rst_n low during WRITE cycle 1 → we_n/ce_n go 1 before next edge, ram_data_oe=0, no dm_ack after release.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// sram_arbiter_pkg: shared definitions for the SRAM controller/arbiter.
//   - state_t     : controller FSM states
//   - BE_*        : active-low byte-enable patterns (whole word, single bytes, none)
//   - *_DEF       : default timing/window parameters
//   - CNT_W       : width of the strobe-cycle counter (supports up to 256 cycles)
//   - in_access() : true for states that drive ce_n low
package sram_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_WREC,
    ST_ACK
  } state_t;

  localparam logic [3:0] BE_WORD  = 4'b0000;
  localparam logic [3:0] BE_BYTE0 = 4'b1110;
  localparam logic [3:0] BE_BYTE1 = 4'b1101;
  localparam logic [3:0] BE_BYTE2 = 4'b1011;
  localparam logic [3:0] BE_BYTE3 = 4'b0111;
  localparam logic [3:0] BE_NONE  = 4'b1111;

  localparam int unsigned RD_CYCLES_DEF = 2;
  localparam int unsigned WR_CYCLES_DEF = 2;
  localparam int unsigned RAM_AW_DEF    = 20;
  localparam logic [31:0] BASE_ADDR_DEF = 32'h8000_0000;
  localparam int unsigned CNT_W         = 8;

  function automatic logic in_access(input state_t s);
    return (s == ST_READ) || (s == ST_WRITE) || (s == ST_WREC);
  endfunction

endpackage

// File: rtl/sram_arb_pick.sv
// sram_arb_pick: combinational grant selection between fetch and data ports.
//   if_req, dm_req : pending requests
//   last_dm        : 1 if the previous grant went to the data port
//   grant_vld      : some port is requesting
//   grant_dm       : 1 = grant data port, 0 = grant fetch port
// Build option: SRAM_ARB_RR_EN selects round-robin between simultaneous
// requesters; otherwise the data port has fixed priority.
module sram_arb_pick (
  input  logic if_req,
  input  logic dm_req,
  input  logic last_dm,
  output logic grant_vld,
  output logic grant_dm
);

`ifdef SRAM_ARB_RR_EN
  always_comb begin
    grant_vld = if_req | dm_req;
    // Contention goes to whichever port was not served last.
    grant_dm  = dm_req & (~if_req | ~last_dm);
  end
`else
  logic unused_last_dm;
  assign unused_last_dm = last_dm;

  always_comb begin
    grant_vld = if_req | dm_req;
    grant_dm  = dm_req;
  end
`endif

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: single-port asynchronous SRAM controller shared by the
// instruction-fetch port (if_*) and the data-memory port (dm_*).
//   clk, rst_n                 : clock, asynchronous active-low reset
//   if_req/if_addr             : fetch request and byte address
//   if_ack/if_err/if_rdata     : one-cycle completion, address error, read word
//   dm_req/dm_we/dm_addr       : data request, write flag, byte address
//   dm_wdata/dm_be_n           : lane-aligned write data, active-low byte enables
//   dm_ack/dm_err/dm_rdata     : one-cycle completion, address error, read word
//   ram_addr/ram_be_n          : SRAM word address and byte enables
//   ram_ce_n/ram_oe_n/ram_we_n : SRAM strobes
//   ram_data_o/ram_data_oe     : write data and bus drive enable
//   ram_data_i                 : SRAM read data
// Build option: SRAM_ARB_RR_EN (see sram_arb_pick) selects round-robin grant.
// All outputs are registered; strobes for a state are loaded from the
// next-state value so they change on the same edge as the state itself.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int unsigned RD_CYCLES = RD_CYCLES_DEF,
  parameter int unsigned WR_CYCLES = WR_CYCLES_DEF,
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF,
  parameter int unsigned RAM_AW    = RAM_AW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_ack,
  output logic              if_err,
  output logic [31:0]       if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [31:0]       dm_addr,
  input  logic [31:0]       dm_wdata,
  input  logic [3:0]        dm_be_n,
  output logic              dm_ack,
  output logic              dm_err,
  output logic [31:0]       dm_rdata,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [3:0]        ram_be_n,
  output logic              ram_ce_n,
  output logic              ram_oe_n,
  output logic              ram_we_n,
  output logic [31:0]       ram_data_o,
  output logic              ram_data_oe,
  input  logic [31:0]       ram_data_i
);

  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_CYCLES - 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_CYCLES - 1);
  // 64-bit bounds so a window ending at 2^32 does not wrap.
  localparam logic [63:0] WIN_LO = {32'd0, BASE_ADDR};
  localparam logic [63:0] WIN_HI = WIN_LO + (64'd4 << RAM_AW);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic             last_dm;
  logic             g_dm;
  logic             grant_vld, grant_dm;
  logic [31:0]      sel_addr;
  logic [3:0]       sel_be;
  logic             sel_we;
  logic             win_ok;
  logic             ce_nx, oe_nx, we_nx, doe_nx;
  logic             ack_dm, ack_err;

  sram_arb_pick u_pick (
    .if_req    (if_req),
    .dm_req    (dm_req),
    .last_dm   (last_dm),
    .grant_vld (grant_vld),
    .grant_dm  (grant_dm)
  );

  assign sel_addr = grant_dm ? dm_addr  : if_addr;
  assign sel_be   = grant_dm ? dm_be_n  : BE_WORD;
  assign sel_we   = grant_dm & dm_we;
  assign win_ok   = ({32'd0, sel_addr} >= WIN_LO) && ({32'd0, sel_addr} < WIN_HI);

  // Leaving IDLE goes straight to ACK only for an address error, so the
  // ack routing/error flag come from the live grant in that case.
  assign ack_dm  = (state == ST_IDLE) ? grant_dm : g_dm;
  assign ack_err = (state == ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (grant_vld) begin
          if (!win_ok)     state_nx = ST_ACK;
          else if (sel_we) state_nx = ST_WRITE;
          else             state_nx = ST_READ;
        end
      end
      ST_READ:  if (cnt == RD_LAST) state_nx = ST_ACK;
      ST_WRITE: if (cnt == WR_LAST) state_nx = ST_WREC;
      ST_WREC:  state_nx = ST_ACK;
      ST_ACK:   state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
    ce_nx  = ~in_access(state_nx);
    oe_nx  = (state_nx != ST_READ);
    we_nx  = (state_nx != ST_WRITE);
    doe_nx = (state_nx == ST_WRITE) || (state_nx == ST_WREC);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      last_dm     <= 1'b0;
      g_dm        <= 1'b0;
      ram_ce_n    <= 1'b1;
      ram_oe_n    <= 1'b1;
      ram_we_n    <= 1'b1;
      ram_data_oe <= 1'b0;
      ram_be_n    <= BE_NONE;
      ram_addr    <= '0;
      ram_data_o  <= '0;
      if_ack      <= 1'b0;
      if_err      <= 1'b0;
      dm_ack      <= 1'b0;
      dm_err      <= 1'b0;
      if_rdata    <= '0;
      dm_rdata    <= '0;
    end else begin
      ram_ce_n    <= ce_nx;
      ram_oe_n    <= oe_nx;
      ram_we_n    <= we_nx;
      ram_data_oe <= doe_nx;
      if_ack      <= 1'b0;
      if_err      <= 1'b0;
      dm_ack      <= 1'b0;
      dm_err      <= 1'b0;

      if (state_nx != state)
        cnt <= '0;
      else if (state == ST_READ || state == ST_WRITE)
        cnt <= cnt + 1'b1;

      if (state == ST_IDLE && grant_vld) begin
        g_dm    <= grant_dm;
        last_dm <= grant_dm;
        if (win_ok) begin
          ram_addr <= sel_addr[RAM_AW+1:2];
          ram_be_n <= sel_be;
          if (sel_we) ram_data_o <= dm_wdata;
        end
      end else if (ce_nx) begin
        ram_be_n <= BE_NONE;
      end

      if (state_nx == ST_ACK) begin
        if (ack_dm) begin
          dm_ack <= 1'b1;
          dm_err <= ack_err;
        end else begin
          if_ack <= 1'b1;
          if_err <= ack_err;
        end
      end

      if (state == ST_READ && state_nx == ST_ACK) begin
        if (g_dm) dm_rdata <= ram_data_i;
        else      if_rdata <= ram_data_i;
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed and randomized bench for sram_arbiter with an
// emulated SRAM and a transaction-level reference model that predicts, per
// granted request, the cycle-by-cycle strobe/ack timeline.
// Build option SRAM_ARB_RR_EN changes the expected grant order.
module tb_sram_arbiter;
  import sram_arbiter_pkg::*;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] WIN  = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
  logic [3:0]  dm_be_n = 4'b0000;
  logic        if_ack, if_err, dm_ack, dm_err;
  logic [31:0] if_rdata, dm_rdata;
  logic [19:0] ram_addr;
  logic [3:0]  ram_be_n;
  logic        ram_ce_n, ram_oe_n, ram_we_n, ram_data_oe;
  logic [31:0] ram_data_o;
  logic [31:0] ram_data_i = '0;

  sram_arbiter #(
    .RD_CYCLES (2),
    .WR_CYCLES (2),
    .BASE_ADDR (BASE),
    .RAM_AW    (20)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .if_req (if_req), .if_addr (if_addr), .if_ack (if_ack), .if_err (if_err), .if_rdata (if_rdata),
    .dm_req (dm_req), .dm_we (dm_we), .dm_addr (dm_addr), .dm_wdata (dm_wdata), .dm_be_n (dm_be_n),
    .dm_ack (dm_ack), .dm_err (dm_err), .dm_rdata (dm_rdata),
    .ram_addr (ram_addr), .ram_be_n (ram_be_n), .ram_ce_n (ram_ce_n), .ram_oe_n (ram_oe_n),
    .ram_we_n (ram_we_n), .ram_data_o (ram_data_o), .ram_data_oe (ram_data_oe), .ram_data_i (ram_data_i)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // ---------------- memories: emulated SRAM and reference copy ----------------
  logic [31:0] sram_mem [logic [19:0]];
  logic [31:0] ref_mem  [logic [19:0]];

  function automatic logic [31:0] init_word(input logic [19:0] w);
    return ({12'h0, w} * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be_n);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++)
      if (!be_n[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] sram_rd(input logic [19:0] w);
    return sram_mem.exists(w) ? sram_mem[w] : init_word(w);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [19:0] w);
    return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
  endfunction

  // SRAM emulation: data presented mid-cycle while selected and output-enabled,
  // write committed on each edge that ends a cycle with we_n low.
  always @(negedge clk)
    ram_data_i = (!ram_ce_n && !ram_oe_n) ? sram_rd(ram_addr) : 32'hDEAD_BEEF;

  always @(posedge clk)
    if (rst_n && !ram_ce_n && !ram_we_n && ram_data_oe)
      sram_mem[ram_addr] = merge(sram_rd(ram_addr), ram_data_o, ram_be_n);

  // ---------------- reference model ----------------
  // ctl = {ce_n, oe_n, we_n, data_oe, be_n[3:0], if_ack, dm_ack, if_err, dm_err}
  typedef struct packed {
    logic [11:0] ctl;
    logic        chk_addr;
    logic        chk_data;
    logic [19:0] addr;
    logic [31:0] data;
    logic        upd_if;
    logic        upd_dm;
    logic [31:0] rval;
    logic        do_wr;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  logic [31:0] m_if_rd, m_dm_rd;
  bit          m_last_dm;

  function automatic exp_t idle_e();
    exp_t e = '0;
    e.ctl = 12'b1110_1111_0000;
    return e;
  endfunction

  function automatic bit in_win(input logic [31:0] a);
    return (a >= BASE) && ({1'b0, a} < ({1'b0, BASE} + {1'b0, WIN}));
  endfunction

  function automatic bit model_grant(input bit i, input bit d, input bit last);
    if (!d) return 1'b0;
    if (!i) return 1'b1;
`ifdef SRAM_ARB_RR_EN
    return !last;
`else
    return last | 1'b1;
`endif
  endfunction

  // Expected outputs for every cycle of one granted transaction, from the
  // cycle after the sampling edge through the IDLE cycle following the ack.
  task automatic build(input bit g);
    logic [31:0] a  = g ? dm_addr : if_addr;
    bit          wr = g && dm_we;
    logic [3:0]  be = g ? dm_be_n : BE_WORD;
    exp_t        e;
    if (!in_win(a)) begin
      e = idle_e();
      e.ctl[3:0] = g ? 4'b0101 : 4'b1010;
      exp_q.push_back(e);
    end else if (!wr) begin
      for (int c = 0; c < 2; c++) begin
        e = '0;
        e.ctl = {4'b0010, be, 4'b0000};
        e.chk_addr = 1'b1;
        e.addr = a[21:2];
        exp_q.push_back(e);
      end
      e = idle_e();
      e.ctl[3:0] = g ? 4'b0100 : 4'b1000;
      e.upd_if = !g;
      e.upd_dm = g;
      e.rval = ref_rd(a[21:2]);
      exp_q.push_back(e);
    end else begin
      for (int c = 0; c < 2; c++) begin
        e = '0;
        e.ctl = {4'b0101, be, 4'b0000};
        e.chk_addr = 1'b1; e.chk_data = 1'b1;
        e.addr = a[21:2]; e.data = dm_wdata;
        exp_q.push_back(e);
      end
      e.ctl = {4'b0111, be, 4'b0000};
      exp_q.push_back(e);
      e = idle_e();
      e.ctl[3:0] = 4'b0100;
      e.ctl[7:4] = BE_NONE;
      e.addr = a[21:2]; e.data = dm_wdata;
      e.do_wr = 1'b1;
      e.rval = {28'h0, be};
      exp_q.push_back(e);
    end
    exp_q.push_back(idle_e());
  endtask

  initial begin
    m_if_rd = '0; m_dm_rd = '0; m_last_dm = 1'b0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        exp_q.delete();
        cur = idle_e();
        cur.chk_addr = 1'b1; cur.chk_data = 1'b1;
        m_if_rd = '0; m_dm_rd = '0; m_last_dm = 1'b0;
      end else begin
        if (exp_q.size() == 0 && (if_req || dm_req)) begin
          m_last_dm = model_grant(if_req, dm_req, m_last_dm);
          build(m_last_dm);
        end
        cur = (exp_q.size() != 0) ? exp_q.pop_front() : idle_e();
        if (cur.upd_if) m_if_rd = cur.rval;
        if (cur.upd_dm) m_dm_rd = cur.rval;
        if (cur.do_wr)  ref_mem[cur.addr] = merge(ref_rd(cur.addr), cur.data, cur.rval[3:0]);
      end
      #1;
      check("ctl", {20'h0, ram_ce_n, ram_oe_n, ram_we_n, ram_data_oe, ram_be_n,
                    if_ack, dm_ack, if_err, dm_err}, {20'h0, cur.ctl});
      if (cur.chk_addr) check("ram_addr", {12'h0, ram_addr}, {12'h0, cur.addr});
      if (cur.chk_data) check("ram_data_o", ram_data_o, cur.data);
      check("if_rdata", if_rdata, m_if_rd);
      check("dm_rdata", dm_rdata, m_dm_rd);
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return $urandom();
      1:       return BASE - 32'd4 + $urandom_range(0, 3);
      2:       return BASE + WIN - 32'd4 + $urandom_range(0, 3);
      3:       return BASE + WIN + $urandom_range(0, 3);
      default: return BASE + ($urandom_range(0, 31) << 2) + $urandom_range(0, 3);
    endcase
  endfunction

  function automatic logic [3:0] rand_be();
    case ($urandom_range(0, 6))
      0: return BE_WORD;
      1: return BE_BYTE0;
      2: return BE_BYTE1;
      3: return BE_BYTE2;
      4: return BE_BYTE3;
      5: return 4'b1100;
      default: return 4'($urandom());
    endcase
  endfunction

  task automatic new_dm();
    dm_addr  = rand_addr();
    dm_we    = 1'($urandom());
    dm_wdata = $urandom();
    dm_be_n  = rand_be();
    dm_req   = 1'b1;
  endtask

  int unsigned cyc, cnt_a, cnt_b, nacks;
  logic [3:0]  order;
  bit          got;

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    sram_mem[20'd4] = 32'h1234_5678; ref_mem[20'd4] = 32'h1234_5678;
    sram_mem[20'd0] = 32'h1122_3344; ref_mem[20'd0] = 32'h1122_3344;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;

    // idle after reset
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("rst_idle", {20'h0, ram_ce_n, ram_oe_n, ram_we_n, ram_data_oe, ram_be_n,
                         if_ack, dm_ack, if_err, dm_err}, 32'h0000_0EF0);
    end

    // fetch read of word 4
    if_addr = 32'h8000_0010; if_req = 1'b1;
    cyc = 0; cnt_a = 0; got = 1'b0;
    while (!got && cyc < 20) begin
      @(negedge clk); cyc++;
      if (!ram_oe_n) cnt_a++;
      if (cyc == 1) check("rd_addr", {12'h0, ram_addr}, 32'd4);
      if (if_ack) got = 1'b1;
    end
    if_req = 1'b0;
    check("rd_ack_cycle", cyc, 3);
    check("rd_oe_cycles", cnt_a, 2);
    check("rd_data", if_rdata, 32'h1234_5678);

    // byte-3 write of word 0
    @(negedge clk);
    dm_addr = 32'h8000_0003; dm_be_n = BE_BYTE3; dm_wdata = 32'hAB00_0000; dm_we = 1'b1; dm_req = 1'b1;
    cyc = 0; cnt_a = 0; cnt_b = 0; got = 1'b0;
    while (!got && cyc < 20) begin
      @(negedge clk); cyc++;
      if (!ram_we_n) begin
        cnt_a++;
        check("wr_be", {28'h0, ram_be_n}, 32'h7);
      end
      if (!ram_ce_n && ram_we_n) begin
        cnt_b++;
        check("wrec_hold", {31'h0, ram_data_oe} ^ ram_data_o, 32'hAB00_0001);
      end
      if (dm_ack) got = 1'b1;
    end
    dm_req = 1'b0;
    check("wr_ack_cycle", cyc, 4);
    check("wr_we_cycles", cnt_a, 2);
    check("wrec_cycles", cnt_b, 1);
    check("wr_mem", sram_rd(20'd0), 32'hAB22_3344);

    // out-of-window data read
    @(negedge clk);
    dm_addr = 32'h0000_1000; dm_we = 1'b0; dm_be_n = BE_WORD; dm_req = 1'b1;
    cyc = 0; cnt_a = 0; got = 1'b0;
    while (!got && cyc < 20) begin
      @(negedge clk); cyc++;
      if (!ram_ce_n) cnt_a++;
      if (dm_ack) begin got = 1'b1; check("err_flag", {31'h0, dm_err}, 32'd1); end
    end
    dm_req = 1'b0;
    @(negedge clk);
    if (!ram_ce_n) cnt_a++;
    check("err_ack_cycle", cyc, 1);
    check("err_no_ce", cnt_a, 0);

    // reset during first write cycle
    @(negedge clk);
    dm_addr = 32'h8000_0020; dm_we = 1'b1; dm_wdata = 32'h5555_AAAA; dm_be_n = BE_WORD; dm_req = 1'b1;
    @(negedge clk);
    check("abort_we_low", {31'h0, ram_we_n}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("abort_strobes", {29'h0, ram_we_n, ram_ce_n, ram_data_oe}, 32'b110);
    dm_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt_a = 0;
    repeat (10) begin @(negedge clk); if (dm_ack) cnt_a++; end
    check("abort_no_ack", cnt_a, 0);
    check("abort_mem", sram_rd(20'd8), init_word(20'd8));

    // both ports requesting continuously for four transactions
    if_addr = BASE + 32'h40; dm_addr = BASE + 32'h44; dm_we = 1'b0;
    if_req = 1'b1; dm_req = 1'b1;
    nacks = 0; cyc = 0; order = '0;
    while (nacks < 4 && cyc < 100) begin
      @(negedge clk); cyc++;
      if (dm_ack) begin order[nacks[1:0]] = 1'b1; nacks++; end
      else if (if_ack) begin order[nacks[1:0]] = 1'b0; nacks++; end
    end
    if_req = 1'b0; dm_req = 1'b0;
    check("grant_count", nacks, 4);
`ifdef SRAM_ARB_RR_EN
    check("grant_order", {28'h0, order}, 32'b0101);
`else
    check("grant_order", {28'h0, order}, 32'b1111);
`endif
    repeat (3) @(negedge clk);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (if_req && if_ack) begin
        if ($urandom_range(0, 1) == 1) if_addr = rand_addr();
        else if_req = 1'b0;
      end else if (!if_req && $urandom_range(0, 2) == 0) begin
        if_addr = rand_addr(); if_req = 1'b1;
      end
      if (dm_req && dm_ack) begin
        if ($urandom_range(0, 1) == 1) new_dm();
        else dm_req = 1'b0;
      end else if (!dm_req && $urandom_range(0, 2) == 0) begin
        new_dm();
      end
    end

    // drain outstanding requests
    cyc = 0;
    while ((if_req || dm_req) && cyc < 200) begin
      @(negedge clk); cyc++;
      if (if_ack) if_req = 1'b0;
      if (dm_ack) dm_req = 1'b0;
    end
    check("drain", {30'h0, if_req, dm_req}, 32'd0);
    if_req = 1'b0; dm_req = 1'b0;
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
